// File: rtl/arty_io_pkg.sv
// Shared types and constants for the Arty A7 button/switch conditioning stage.
package arty_io_pkg;

  typedef enum logic {
    DB_STABLE = 1'b0,
    DB_CHECK  = 1'b1
  } debounce_state_e;

  localparam int BTN_CH_BASE             = 0;
  localparam int SW_CH_BASE              = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/arty_input_debouncer_if.sv
// Pin-side and SoC-side signal bundle of the debouncer; master drives pins and controls.
interface arty_input_debouncer_if #(
  parameter int N_CH = 8
);
  logic [N_CH-1:0] raw_i;
  logic [N_CH-1:0] level_o;
  logic [N_CH-1:0] rise_o;
  logic [N_CH-1:0] fall_o;
  logic [N_CH-1:0] event_o;
  logic [N_CH-1:0] event_clr_i;
  logic [N_CH-1:0] irq_en_i;
  logic            irq_o;

  // No handshake: levels are sampled every cycle, rise/fall are single-cycle
  // strobes, and event_o stays high until cleared by event_clr_i.
  modport master (
    output raw_i, event_clr_i, irq_en_i,
    input  level_o, rise_o, fall_o, event_o, irq_o
  );

  modport slave (
    input  raw_i, event_clr_i, irq_en_i,
    output level_o, rise_o, fall_o, event_o, irq_o
  );
endinterface

// File: rtl/debounce_channel.sv
// One input channel: synchroniser chain, STABLE/CHECK counter FSM, and registered
// level with single-cycle rise/fall strobes aligned to the level change.
module debounce_channel
  import arty_io_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            raw,
  output logic            level,
  output logic            rise,
  output logic            fall,
  output debounce_state_e state
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  debounce_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic level_q, level_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Any sample matching the current level while in CHECK restarts the count,
  // so the terminal value is only reached after an unbroken run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      DB_STABLE: begin
        if (s != level_q) begin
          state_d = DB_CHECK;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      DB_CHECK: begin
        if (s == level_q) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
          level_d = s;
          rise_d  = s;
          fall_d  = ~s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign state = state_q;

endmodule

// File: rtl/arty_input_debouncer.sv
// Debounces N_CH board pins and keeps sticky per-channel event flags plus a
// registered, maskable interrupt for the SoC GPIO block.
module arty_input_debouncer
  import arty_io_pkg::*;
#(
  parameter int              N_CH            = 8,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [N_CH-1:0] RESET_LEVEL     = '0
) (
  input  logic            CLK100MHZ,
  input  logic            ck_rst,
  input  logic [N_CH-1:0] raw_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic [N_CH-1:0] event_o,
  input  logic [N_CH-1:0] event_clr_i,
  input  logic [N_CH-1:0] irq_en_i,
  output logic            irq_o
);

  logic [N_CH-1:0] event_q;
  logic            irq_q;
  logic [N_CH-1:0] db_check;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_state_e ch_state;

    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL[i])
    ) u_channel (
      .clk  (CLK100MHZ),
      .rst_n(ck_rst),
      .raw  (raw_i[i]),
      .level(level_o[i]),
      .rise (rise_o[i]),
      .fall (fall_o[i]),
      .state(ch_state)
    );

    assign db_check[i] = (ch_state == DB_CHECK);
  end

  // A new edge outranks a simultaneous clear so no press is ever lost.
  always_ff @(posedge CLK100MHZ) begin
    if (!ck_rst) begin
      event_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      event_q <= (rise_o | fall_o) | (event_q & ~event_clr_i);
      irq_q   <= |(event_q & irq_en_i);
    end
  end

  assign event_o = event_q;
  assign irq_o   = irq_q;

  // Per-channel FSM phase, kept visible for checker binding.
  logic unused_db_check;
  assign unused_db_check = ^db_check;

endmodule

// File: tb/tb_arty_input_debouncer.sv
// Directed bench for arty_input_debouncer with DEBOUNCE_CYCLES=16, SYNC_STAGES=2.
module tb_arty_input_debouncer;

  localparam int N_CH = 8;
  localparam int DB   = 16;
  localparam int LAT  = DB + 2;

  logic clk;
  logic ck_rst;
  int   checks = 0;
  int   errors = 0;
  int   rise_cnt[N_CH];
  int   fall_cnt[N_CH];

  arty_input_debouncer_if #(.N_CH(N_CH)) bus ();

  arty_input_debouncer #(
    .N_CH           (N_CH),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(DB),
    .RESET_LEVEL    ('0)
  ) dut (
    .CLK100MHZ  (clk),
    .ck_rst     (ck_rst),
    .raw_i      (bus.raw_i),
    .level_o    (bus.level_o),
    .rise_o     (bus.rise_o),
    .fall_o     (bus.fall_o),
    .event_o    (bus.event_o),
    .event_clr_i(bus.event_clr_i),
    .irq_en_i   (bus.irq_en_i),
    .irq_o      (bus.irq_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (bus.rise_o[i]) rise_cnt[i]++;
      if (bus.fall_o[i]) fall_cnt[i]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_pulse_counts();
    for (int i = 0; i < N_CH; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
  endtask

  task automatic clear_events();
    bus.event_clr_i = '1;
    step(1);
    bus.event_clr_i = '0;
  endtask

  initial begin
    ck_rst          = 1'b0;
    bus.raw_i       = '0;
    bus.event_clr_i = '0;
    bus.irq_en_i    = '0;
    clear_pulse_counts();
    step(3);
    check("rst_level", bus.level_o, 0);
    check("rst_rise", bus.rise_o, 0);
    check("rst_event", bus.event_o, 0);
    check("rst_irq", bus.irq_o, 0);
    ck_rst = 1'b1;
    step(1);

    // 1: clean press on ch0
    bus.irq_en_i = 8'h01;
    bus.raw_i[0] = 1'b1;
    step(LAT - 1);
    check("t1_level_early", bus.level_o[0], 0);
    step(1);
    check("t1_level", bus.level_o[0], 1);
    check("t1_rise", bus.rise_o, 8'h01);
    step(1);
    check("t1_rise_gone", bus.rise_o[0], 0);
    check("t1_event", bus.event_o, 8'h01);
    check("t1_irq_lag", bus.irq_o, 0);
    step(1);
    check("t1_irq", bus.irq_o, 1);
    clear_events();
    step(2);
    check("t1_cleared", bus.event_o, 0);
    check("t1_irq_cleared", bus.irq_o, 0);
    bus.irq_en_i = '0;

    // 2: bouncing ch1
    clear_pulse_counts();
    bus.raw_i[1] = 1'b1; step(5);
    bus.raw_i[1] = 1'b0; step(3);
    bus.raw_i[1] = 1'b1; step(7);
    bus.raw_i[1] = 1'b0; step(3);
    check("t2_bounce_rise", rise_cnt[1], 0);
    check("t2_bounce_level", bus.level_o[1], 0);
    bus.raw_i[1] = 1'b1;
    step(LAT - 1);
    check("t2_level_early", bus.level_o[1], 0);
    step(1);
    check("t2_level", bus.level_o[1], 1);
    check("t2_rise", bus.rise_o[1], 1);
    step(3);
    check("t2_rise_count", rise_cnt[1], 1);
    check("t2_fall_count", fall_cnt[1], 0);

    // 3: 15-cycle glitch on ch2
    bus.raw_i[2] = 1'b1; step(DB - 1);
    bus.raw_i[2] = 1'b0; step(LAT + 4);
    check("t3_level", bus.level_o[2], 0);
    check("t3_rise", rise_cnt[2], 0);
    check("t3_fall", fall_cnt[2], 0);
    check("t3_event", bus.event_o[2], 0);

    // 4: clear colliding with set on ch3
    bus.raw_i[3] = 1'b1;
    step(LAT);
    check("t4_level_hi", bus.level_o[3], 1);
    step(1);
    clear_events();
    step(1);
    check("t4_pre_event", bus.event_o, 0);
    bus.irq_en_i = 8'h08;
    bus.raw_i[3] = 1'b0;
    step(LAT);
    check("t4_fall", bus.fall_o[3], 1);
    check("t4_level_lo", bus.level_o[3], 0);
    bus.event_clr_i = 8'h08;
    step(1);
    bus.event_clr_i = 8'h00;
    check("t4_set_wins", bus.event_o[3], 1);
    check("t4_irq_pre", bus.irq_o, 0);
    bus.event_clr_i = 8'h08;
    step(1);
    bus.event_clr_i = 8'h00;
    check("t4_cleared", bus.event_o[3], 0);
    check("t4_irq_still", bus.irq_o, 1);
    step(1);
    check("t4_irq_drop", bus.irq_o, 0);
    bus.irq_en_i = '0;

    // 5: reset at count 10 of a ch4 transition
    bus.raw_i[4] = 1'b1;
    step(11);
    ck_rst = 1'b0;
    step(1);
    ck_rst = 1'b1;
    clear_pulse_counts();
    check("t5_level_rst", bus.level_o, 0);
    check("t5_event_rst", bus.event_o, 0);
    step(LAT - 1);
    check("t5_level_early", bus.level_o[4], 0);
    check("t5_no_pulse", rise_cnt[4], 0);
    step(1);
    check("t5_level_all", bus.level_o, 8'h13);
    check("t5_rise", bus.rise_o, 8'h13);

    // 6: all channels at once
    bus.raw_i = '0;
    step(LAT + 2);
    clear_events();
    step(1);
    check("t6_idle", bus.level_o, 0);
    bus.raw_i = 8'hFF;
    step(LAT - 1);
    check("t6_level_early", bus.level_o, 0);
    step(1);
    check("t6_rise", bus.rise_o, 8'hFF);
    check("t6_level", bus.level_o, 8'hFF);
    step(1);
    check("t6_event", bus.event_o, 8'hFF);
    check("t6_rise_gone", bus.rise_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
